// File: rtl/lcd_write_sequencer.sv
// Avalon-MM master that buffers LCD command/data bytes, runs the HD44780 power-up init and times each write.
// Build option LCD_BUSY_POLL_EN: completion by busy-flag polling instead of fixed post-write delays.
module lcd_write_sequencer #(
  parameter int FIFO_DEPTH      = 8,
  parameter int SETUP_CYCLES    = 3,
  parameter int E_CYCLES        = 25,
  parameter int HOLD_CYCLES     = 2,
  parameter int POWERUP_CYCLES  = 750000,
  parameter int INIT_GAP_CYCLES = 205000,
  parameter int EXEC_CYCLES     = 2500,
  parameter int CLEAR_CYCLES    = 82000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_rs,
  output logic [1:0] avm_address,
  output logic       avm_write,
  output logic       avm_read,
  output logic [7:0] avm_writedata,
  input  logic [7:0] avm_readdata,
  output logic       init_done,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

  // Every phase loads (count - 1) and leaves when the down-counter reaches zero.
  localparam logic [19:0] C_POWERUP = 20'(POWERUP_CYCLES - 1);
  localparam logic [19:0] C_GAP     = 20'(INIT_GAP_CYCLES - 1);
  localparam logic [19:0] C_SETUP   = 20'(SETUP_CYCLES - 1);
  localparam logic [19:0] C_E       = 20'(E_CYCLES - 1);
  localparam logic [19:0] C_HOLD    = 20'(HOLD_CYCLES - 1);
  localparam logic [19:0] C_EXEC    = 20'(EXEC_CYCLES - 1);
  localparam logic [19:0] C_CLEAR   = 20'(CLEAR_CYCLES - 1);

  typedef enum logic [3:0] {
    PWRUP,
    IDLE,
    SETUP,
    STROBE,
    HOLD,
`ifdef LCD_BUSY_POLL_EN
    PSETUP,
    PSTROBE,
    PHOLD,
`endif
    WAIT
  } state_t;

  function automatic logic [7:0] init_byte(input logic [2:0] i);
    case (i)
      3'd4:    return 8'h0C;
      3'd5:    return 8'h01;
      3'd6:    return 8'h06;
      default: return 8'h38;
    endcase
  endfunction

`ifndef LCD_BUSY_POLL_EN
  // Clear-display and return-home need the long execution delay.
  function automatic logic [19:0] exec_delay(input logic rs, input logic [7:0] b);
    return (!rs && (b == 8'h01 || b == 8'h02)) ? C_CLEAR : C_EXEC;
  endfunction
`endif

  state_t        state, state_n;
  logic [19:0]   cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic          init_done_n;
  logic          cur_rs, cur_rs_n;
  logic [7:0]    cur_data_n;
  logic [1:0]    addr_n;
  logic          finish;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_n;
  logic          push, pop;
  logic [8:0]    head;
  logic          unused_in;

  assign push    = in_valid && in_ready;
  assign head    = mem[rd_ptr];
  assign count_n = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_rs, in_data};
  end

`ifdef LCD_BUSY_POLL_EN
  logic busy_flag, busy_flag_n;
  assign unused_in = ^{avm_readdata[6:0], C_EXEC, C_CLEAR};
`else
  assign unused_in = ^avm_readdata;
  assign avm_read  = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = idx;
    init_done_n = init_done;
    cur_rs_n    = cur_rs;
    cur_data_n  = avm_writedata;
    pop         = 1'b0;
    finish      = 1'b0;
`ifdef LCD_BUSY_POLL_EN
    busy_flag_n = busy_flag;
`endif
    if (cnt != '0) cnt_n = cnt - 20'd1;

    case (state)
      PWRUP: if (cnt == '0) begin
        state_n    = SETUP;
        cnt_n      = C_SETUP;
        idx_n      = '0;
        cur_rs_n   = 1'b0;
        cur_data_n = init_byte(3'd0);
      end
      IDLE: if (init_done && count != '0) begin
        pop        = 1'b1;
        state_n    = SETUP;
        cnt_n      = C_SETUP;
        cur_rs_n   = head[8];
        cur_data_n = head[7:0];
      end
      SETUP: if (cnt == '0) begin
        state_n = STROBE;
        cnt_n   = C_E;
      end
      STROBE: if (cnt == '0) begin
        state_n = HOLD;
        cnt_n   = C_HOLD;
      end
      HOLD: if (cnt == '0) begin
        // The three raw 0x38 wake-up writes precede a valid busy flag, so they always use a fixed gap.
        if (!init_done && idx < 3'd3) begin
          state_n = WAIT;
          cnt_n   = C_GAP;
        end else begin
`ifdef LCD_BUSY_POLL_EN
          state_n = PSETUP;
          cnt_n   = C_SETUP;
`else
          state_n = WAIT;
          cnt_n   = exec_delay(cur_rs, avm_writedata);
`endif
        end
      end
      WAIT: if (cnt == '0) finish = 1'b1;
`ifdef LCD_BUSY_POLL_EN
      PSETUP: if (cnt == '0) begin
        state_n = PSTROBE;
        cnt_n   = C_E;
      end
      PSTROBE: if (cnt == '0) begin
        busy_flag_n = avm_readdata[7];
        state_n     = PHOLD;
        cnt_n       = C_HOLD;
      end
      PHOLD: if (cnt == '0) begin
        if (busy_flag) begin
          state_n = PSETUP;
          cnt_n   = C_SETUP;
        end else begin
          finish = 1'b1;
        end
      end
`endif
      default: state_n = PWRUP;
    endcase

    if (finish) begin
      state_n = IDLE;
      if (!init_done) begin
        if (idx == 3'd6) begin
          init_done_n = 1'b1;
        end else begin
          idx_n      = idx + 3'd1;
          state_n    = SETUP;
          cnt_n      = C_SETUP;
          cur_rs_n   = 1'b0;
          cur_data_n = init_byte(idx + 3'd1);
        end
      end
    end

    addr_n = avm_address;
    case (state_n)
      SETUP, STROBE, HOLD: addr_n = {cur_rs_n, 1'b0};
`ifdef LCD_BUSY_POLL_EN
      PSETUP, PSTROBE, PHOLD: addr_n = 2'b01;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= PWRUP;
      cnt           <= C_POWERUP;
      idx           <= '0;
      init_done     <= 1'b0;
      cur_rs        <= 1'b0;
      avm_writedata <= 8'h00;
      avm_address   <= 2'b00;
      avm_write     <= 1'b0;
      busy          <= 1'b1;
      in_ready      <= 1'b1;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      idx           <= idx_n;
      init_done     <= init_done_n;
      cur_rs        <= cur_rs_n;
      avm_writedata <= cur_data_n;
      avm_address   <= addr_n;
      avm_write     <= (state_n == STROBE);
      busy          <= (state_n != IDLE) || (count_n != '0);
      in_ready      <= (count_n < DEPTH_C);
      count         <= count_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

`ifdef LCD_BUSY_POLL_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avm_read  <= 1'b0;
      busy_flag <= 1'b0;
    end else begin
      avm_read  <= (state_n == PSTROBE);
      busy_flag <= busy_flag_n;
    end
  end
`endif

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Scoreboard bench for lcd_write_sequencer: expected LCD writes are queued by the stimulus and
// checked by a bus monitor for order, content, strobe timing and post-write delays.
module tb_lcd_write_sequencer;

  localparam int FIFO_DEPTH = 4;
  localparam int POWERUP    = 20;
  localparam int GAP        = 10;
  localparam int SETUP      = 2;
  localparam int E          = 4;
  localparam int HOLD       = 1;
  localparam int EXEC       = 6;
  localparam int CLEAR      = 15;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_rs = 1'b0;
  logic [1:0] avm_address;
  logic       avm_write;
  logic       avm_read;
  logic [7:0] avm_writedata;
  logic [7:0] avm_readdata = 8'h00;
  logic       init_done;
  logic       busy;

  lcd_write_sequencer #(
    .FIFO_DEPTH(FIFO_DEPTH), .SETUP_CYCLES(SETUP), .E_CYCLES(E), .HOLD_CYCLES(HOLD),
    .POWERUP_CYCLES(POWERUP), .INIT_GAP_CYCLES(GAP), .EXEC_CYCLES(EXEC), .CLEAR_CYCLES(CLEAR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_rs(in_rs), .avm_address(avm_address), .avm_write(avm_write),
    .avm_read(avm_read), .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .init_done(init_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    bit         is_gap;
    bit         user;
    int         push_cyc;
    bit         idle;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int rel_cyc = 0;
  logic [7:0] init_list [7] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  task automatic check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Post-write delay the LCD needs for an entry, independent of how the sequencer gets there.
  function automatic int wait_of(input exp_t e);
    if (e.is_gap) return GAP;
    if (!e.rs && (e.data == 8'h01 || e.data == 8'h02)) return CLEAR;
    return EXEC;
  endfunction

  task automatic load_init();
    for (int i = 0; i < 7; i++)
      sb.push_back('{rs: 1'b0, data: init_list[i], is_gap: (i < 3), user: 1'b0, push_cyc: -1, idle: 1'b0});
  endtask

  // Called at a negedge; leaves the bench at a later negedge with in_valid low.
  task automatic push_byte(input logic rs, input logic [7:0] d);
    int t = 0;
    in_valid = 1'b1;
    in_rs    = rs;
    in_data  = d;
    while (!in_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check(1'b0, "push_timeout", 0, 1);
    else sb.push_back('{rs: rs, data: d, is_gap: 1'b0, user: 1'b1, push_cyc: cyc, idle: !busy});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic push_random(input int n);
    logic       rs;
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rs = 1'($urandom_range(0, 1));
      d  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) begin
        rs = 1'b0;
        d  = 8'h01 + 8'($urandom_range(0, 1));
      end
      push_byte(rs, d);
    end
  endtask

  task automatic wait_init();
    int t = 0;
    while (!init_done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check(init_done, "init_done_timeout", init_done, 1);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((sb.size() != 0 || busy) && t < 10000) begin
      @(negedge clk);
      t++;
    end
    check(sb.size() == 0 && !busy, "drain_timeout", sb.size(), 0);
  endtask

  // Busy-flag responder: each write reports busy for two polls, then ready.
  initial begin : responder
    int   left;
    logic pw, pr;
    left = 0;
    pw   = 1'b0;
    pr   = 1'b0;
    forever begin
      @(negedge clk);
      if (avm_write && !pw) left = 2;
      if (avm_read && !pr) begin
        avm_readdata = (left > 0) ? 8'h80 : 8'h00;
        if (left > 0) left--;
      end
      pw = avm_write;
      pr = avm_read;
    end
  end

  initial begin : monitor
    logic       pw, pr, pinit;
    logic [1:0] paddr, waddr;
    logic [7:0] pdata, wdata;
    int         plen, hold_left, setup_run, nwrites, nreads, fall_c, g, w;
    bit         have_prev;
    exp_t       prev, cur;
    pw = 0; pr = 0; pinit = 0; paddr = 0; waddr = 0; pdata = 0; wdata = 0;
    plen = 0; hold_left = 0; setup_run = 0; nwrites = 0; nreads = 0; fall_c = 0; have_prev = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pw = 0; pr = 0; pinit = 0; plen = 0; hold_left = 0; setup_run = 0;
        nwrites = 0; nreads = 0; have_prev = 0;
        continue;
      end
      check(!(avm_write && avm_read), "rw_exclusive", {avm_write, avm_read}, 0);
      if (avm_write && !pw) begin
        nwrites++;
        check(setup_run >= SETUP, "setup_time", setup_run, SETUP);
        if (nwrites == 1) check(cyc - rel_cyc == POWERUP + SETUP, "first_write_latency", cyc - rel_cyc, POWERUP + SETUP);
        if (sb.size() == 0) begin
          check(1'b0, "unexpected_write", avm_writedata, 0);
        end else begin
          cur = sb.pop_front();
          check(avm_address == {cur.rs, 1'b0}, "write_addr", avm_address, {cur.rs, 1'b0});
          check(avm_writedata == cur.data, "write_data", avm_writedata, cur.data);
          if (cur.user && cur.idle) check(cyc - cur.push_cyc == 2 + SETUP, "idle_latency", cyc - cur.push_cyc, 2 + SETUP);
          if (have_prev) begin
            // Gap between end of HOLD and start of SETUP; a FIFO entry also spends one IDLE cycle.
            g = (cyc - SETUP) - (fall_c + HOLD);
            w = wait_of(prev) + (cur.user ? 1 : 0);
`ifdef LCD_BUSY_POLL_EN
            check(nreads == (prev.is_gap ? 0 : 3), "poll_reads", nreads, prev.is_gap ? 0 : 3);
            if (prev.is_gap) check(g == w, "wait_gap", g, w);
`else
            check(nreads == 0, "no_reads", nreads, 0);
            if (cur.push_cyc < fall_c) check(g == w, "wait_gap", g, w);
            else check(g >= w, "wait_gap_min", g, w);
`endif
          end
          prev = cur;
          have_prev = 1;
          nreads = 0;
        end
        waddr = avm_address;
        wdata = avm_writedata;
        plen  = 1;
      end else if (avm_write) begin
        plen++;
        check(avm_address == waddr && avm_writedata == wdata, "strobe_stable", avm_writedata, wdata);
      end
      if (!avm_write && pw) begin
        check(plen == E, "e_width", plen, E);
        fall_c    = cyc;
        hold_left = HOLD;
      end
      if (!avm_write && hold_left > 0) begin
        check(avm_address == waddr && avm_writedata == wdata && !avm_read, "hold_stable", avm_address, waddr);
        hold_left--;
      end
      if (avm_read && !pr) nreads++;
      if (avm_read) check(avm_address == 2'b01, "read_addr", avm_address, 1);
      if (init_done && !pinit) check(nwrites == 7, "init_write_count", nwrites, 7);
      if (!avm_write && !avm_read)
        setup_run = (avm_address == paddr && avm_writedata == pdata && !pw && !pr) ? setup_run + 1 : 1;
      else
        setup_run = 0;
      pw = avm_write; pr = avm_read; pinit = init_done; paddr = avm_address; pdata = avm_writedata;
    end
  end

  initial begin : stim
    int t;
    int acc;
    load_init();
    #1 reset_n = 1'b0;
    #1;
    check(avm_write == 1'b0, "rst_write", avm_write, 0);
    check(avm_read == 1'b0, "rst_read", avm_read, 0);
    check(avm_address == 2'b00, "rst_addr", avm_address, 0);
    check(avm_writedata == 8'h00, "rst_wdata", avm_writedata, 0);
    check(init_done == 1'b0, "rst_init_done", init_done, 0);
    check(busy == 1'b1, "rst_busy", busy, 1);
    check(in_ready == 1'b1, "rst_in_ready", in_ready, 1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    rel_cyc = cyc;

    wait_init();
    push_byte(1'b1, 8'h41);
    push_byte(1'b0, 8'h01);
    push_byte(1'b1, 8'h42);
    push_random(20);
    wait_drain();

    // Reset in the middle of a strobe with bytes still queued.
    push_byte(1'b1, 8'h55);
    push_byte(1'b0, 8'h80);
    push_byte(1'b1, 8'h66);
    t = 0;
    while (!avm_write && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check(avm_write, "strobe_before_reset", avm_write, 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check(avm_write == 1'b0, "async_write_drop", avm_write, 0);
    check(avm_read == 1'b0, "async_read_drop", avm_read, 0);
    check(in_ready == 1'b1, "flush_in_ready", in_ready, 1);
    check(init_done == 1'b0, "reinit_done_low", init_done, 0);
    check(busy == 1'b1, "reset_busy", busy, 1);
    sb.delete();
    load_init();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    rel_cyc = cyc;

    // Burst while stalled in PWRUP: only FIFO_DEPTH bytes fit.
    @(negedge clk);
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_rs    = 1'b1;
      in_data  = 8'h30 + 8'(i);
      if (in_ready) begin
        sb.push_back('{rs: 1'b1, data: 8'h30 + 8'(i), is_gap: 1'b0, user: 1'b1, push_cyc: cyc, idle: 1'b0});
        acc++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check(acc == FIFO_DEPTH, "burst_accepts", acc, FIFO_DEPTH);
    check(in_ready == 1'b0, "full_in_ready", in_ready, 0);
    check(init_done == 1'b0, "stalled_in_pwrup", init_done, 0);

    wait_init();
    push_random(15);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
